seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for the board's 8-digit common-anode 7-segment display.
//  Consumes the 32-bit packed BCD word produced by the binary-to-BCD stage:
//  8 nibbles, digit i = bcd[4i+3:4i], digit 0 rightmost.
//  Scans one digit at a time, with tear-free frame updates, leading-zero blanking,
//  per-digit enables and an anti-ghosting guard interval.
// PARAMETERS
//  SCAN_DIV    100000  clk cycles per digit slot (100 MHz -> 1 kHz slot, 125 Hz frame); legal range >= GUARD+1
//  GUARD       2       cycles at start of each slot with all anodes off; legal range >= 0, < SCAN_DIV
//  ACTIVE_LOW  1       1: an/seg active-low; 0: active-high
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous reset, active-high
//  bcd         in   32  packed digits; nibbles 10..15 are shown as hex glyphs
//  dp          in   8   decimal point per digit
//  digit_en    in   8   per-digit enable mask
//  lz_blank    in   1   leading-zero suppression enable
//  load        in   1   capture bcd/dp/digit_en/lz_blank into the pending register
//  an          out  8   anode select, one-hot when active
//  seg         out  8   {dp,g,f,e,d,c,b,a}
//  frame_done  out  1   1-cycle pulse at the last cycle of slot 7
// BEHAVIOUR
//  Reset (async, immediate):
//   - prescaler=0, idx=0; pending and active registers cleared (digit_en=0).
//   - an, seg = all inactive (8'hFF when ACTIVE_LOW); frame_done=0.
//  Prescaler:
//   - counts 0..SCAN_DIV-1, then wraps to 0.
//   - on wrap, idx increments mod 8 (7 -> 0).
//   - frame_done=1 exactly when prescaler==SCAN_DIV-1 && idx==7.
//  Update path:
//   - load=1 at an edge writes the pending register and sets pend_v.
//   - A later load before transfer overwrites it (last wins).
//   - At the frame wrap edge (frame_done=1): if load=1 that same cycle, the input values go
//     straight to active; else if pend_v, pending -> active. pend_v is then cleared.
//   - Active content never changes mid-frame.
//  Blanking:
//   - Digit i is blanked if digit_en[i]==0.
//   - Digit i is also blanked if lz_blank && i!=0 && all nibbles i..7 are 0 && dp[7:i]==0.
//   - Digit 0 is never LZ-blanked.
//   - Blanked slot: an all inactive, seg all off (dp off too).
//  Glyphs (active-high, {g..a}):
//   - 0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07
//   - 8:7F  9:6F  A:77  b:7C  C:39  d:5E  E:79  F:71
//   - seg[7]=dp[i]; invert all of seg when ACTIVE_LOW.
//  Timing:
//   - an/seg are registered: they reflect idx/prescaler/active one cycle late.
//   - an is driven for slot idx only while prescaler >= GUARD (guard cycles: an all inactive,
//     seg still valid).
//   - At most one an bit is active in any cycle.
//  Reset mid-operation: the scan restarts at digit 0 with the display dark until a load plus
//   a frame wrap occur.
// TESTING (SCAN_DIV=4, GUARD=1, ACTIVE_LOW=1 unless noted)
//  1. Assert rst mid-slot, asynchronously -> an=FF, seg=FF, frame_done=0 in the same cycle;
//     after release, the first frame is dark.
//  2. load bcd=32'h12345678, en=FF, dp=0 -> after the next frame wrap:
//     slot0 an=FE seg=80 ('8'); slot1 an=FD seg=F8 ('7');
//     guard cycle of each slot has an=FF.
//  3. bcd=32'h00000305, lz_blank=1, en=FF -> slots 7..3 an=FF;
//     slot2 seg=B0; slot1 seg=C0; slot0 seg=92.
//     With bcd=0: only slot0 lit, seg=C0.
//  4. bcd=0, lz_blank=1, dp=8'h20 -> digits 5..0 lit; slot5 seg=40 (0 with dp); slots 7,6 dark.
//  5. Two loads mid-frame (A, then B) -> display unchanged until wrap, then shows B;
//     frame_done high exactly one cycle per 32 cycles.
//  6. Nibble 0xA, en=8'h01 -> slot0 seg=88; all other slots an=FF.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// Bus bundle for the 8-digit 7-segment scan driver.
// The master side supplies frame data; the driver side produces the display outputs.
interface seg7_scan_driver_if;
  logic [31:0] bcd;
  logic [7:0]  dp;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic        load;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output bcd, dp, digit_en, lz_blank, load,
    input  an, seg, frame_done
  );

  modport slave (
    input  bcd, dp, digit_en, lz_blank, load,
    output an, seg, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit 7-segment driver with tear-free frame updates,
// leading-zero blanking, per-digit enables and an anode guard interval.
module seg7_scan_driver #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned GUARD      = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seg7_scan_driver_if.slave bus
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] GRD  = PW'(GUARD);
  localparam logic [7:0]    OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;

  typedef struct packed {
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
  } frame_t;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  frame_t        pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  frame_t        act_q, act_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          wrap;
  logic          frame_end;
  frame_t        in_frame;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          blank;
  logic [7:0]    an_raw;
  logic [7:0]    seg_raw;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    unique case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      4'hF: g = 7'h71;
    endcase
    return g;
  endfunction

  assign in_frame = '{
    bcd: bus.bcd,
    dp:  bus.dp,
    en:  bus.digit_en,
    lz:  bus.lz_blank
  };

  // Slot prescaler and digit index; frame ends on the last cycle of slot 7.
  always_comb begin
    wrap      = (presc_q == LAST);
    frame_end = wrap && (idx_q == 3'd7);
    presc_d   = wrap ? '0 : presc_q + PW'(1);
    idx_d     = wrap ? idx_q + 3'd1 : idx_q;
  end

  // Pending/active frame registers; active only changes at the frame boundary.
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    act_d    = act_q;
    if (bus.load) begin
      pend_d   = in_frame;
      pend_v_d = 1'b1;
    end
    if (frame_end) begin
      if (bus.load) begin
        act_d = in_frame;
      end else if (pend_v_q) begin
        act_d = pend_q;
      end
      pend_v_d = 1'b0;
    end
  end

  // Blanking and glyph lookup for the current slot, registered next cycle.
  always_comb begin
    nib        = act_q.bcd[{idx_q, 2'b00} +: 4];
    upper_zero = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j >= int'(idx_q)) begin
        if (act_q.bcd[j*4 +: 4] != 4'h0 || act_q.dp[j]) begin
          upper_zero = 1'b0;
        end
      end
    end
    blank = !act_q.en[idx_q] ||
            (act_q.lz && (idx_q != 3'd0) && upper_zero);
    seg_raw = blank ? 8'h00 : {act_q.dp[idx_q], glyph(nib)};
    an_raw  = (blank || (presc_q < GRD)) ? 8'h00 : (8'h01 << idx_q);
    an_d    = an_raw ^ OFF;
    seg_d   = seg_raw ^ OFF;
  end

  // State registers with asynchronous reset to a dark display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      idx_q    <= 3'd0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      act_q    <= '0;
      an_q     <= OFF;
      seg_q    <= OFF;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      act_q    <= act_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based model
// of the scan schedule, frame update rules and blanking rules.
module tb_seg7_scan_driver;

  localparam int unsigned SD = 4;
  localparam int unsigned GD = 1;
  localparam int unsigned FRAME = SD * 8;

  typedef struct {
    logic [31:0] bcd;
    logic [7:0]  dp;
    logic [7:0]  en;
    logic        lz;
  } mframe_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .SCAN_DIV(SD),
    .GUARD(GD),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] glyph_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int unsigned n;
  mframe_t     act;
  mframe_t     pend;
  bit          pv;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t n=%0d)",
               tag, got, exp, $time, n);
    end
  endtask

  function automatic logic [15:0] disp(input int unsigned cnt,
                                       input mframe_t a);
    int unsigned slot;
    int unsigned phase;
    logic [31:0] hi;
    logic [7:0]  dhi;
    logic [3:0]  digit;
    bit          blank;
    logic [7:0]  s;
    logic [7:0]  an;
    slot  = (cnt / SD) % 8;
    phase = cnt % SD;
    hi    = a.bcd >> (4 * slot);
    dhi   = a.dp >> slot;
    digit = hi[3:0];
    blank = !a.en[slot] ||
            (a.lz && slot != 0 && hi == 0 && dhi == 0);
    s  = blank ? 8'h00 : {a.dp[slot], glyph_tbl[digit]};
    an = (blank || phase < GD) ? 8'h00 : 8'(1 << slot);
    return {~an, ~s};
  endfunction

  task automatic model_reset();
    n    = 0;
    act  = '{bcd: 32'h0, dp: 8'h0, en: 8'h0, lz: 1'b0};
    pend = act;
    pv   = 1'b0;
  endtask

  task automatic cyc(input logic ld, input logic [31:0] b,
                     input logic [7:0] d, input logic [7:0] e,
                     input logic l);
    logic [15:0] exp;
    bit          fe;
    mframe_t     inf;
    bus.load     = ld;
    bus.bcd      = b;
    bus.dp       = d;
    bus.digit_en = e;
    bus.lz_blank = l;
    inf = '{bcd: b, dp: d, en: e, lz: l};
    exp = disp(n, act);
    fe  = (n % FRAME) == FRAME - 1;
    chk("frame_done", 32'(bus.frame_done), 32'(fe));
    if (ld) begin
      pend = inf;
      pv   = 1'b1;
    end
    if (fe) begin
      if (ld) act = inf;
      else if (pv) act = pend;
      pv = 1'b0;
    end
    n++;
    @(posedge clk);
    #1;
    chk("an", 32'(bus.an), 32'(exp[15:8]));
    chk("seg", 32'(bus.seg), 32'(exp[7:0]));
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, $urandom, 8'($urandom), 8'($urandom), 1'b1);
  endtask

  task automatic ld_run(input logic [31:0] b, input logic [7:0] d,
                        input logic [7:0] e, input logic l);
    cyc(1'b1, b, d, e, l);
    idle(2 * FRAME);
  endtask

  initial begin
    logic [31:0] rb;
    bus.load     = 1'b0;
    bus.bcd      = 32'h0;
    bus.dp       = 8'h0;
    bus.digit_en = 8'h0;
    bus.lz_blank = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_an", 32'(bus.an), 32'hFF);
    chk("rst_seg", 32'(bus.seg), 32'hFF);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    ld_run(32'h12345678, 8'h00, 8'hFF, 1'b0);
    ld_run(32'h00000305, 8'h00, 8'hFF, 1'b1);
    ld_run(32'h00000000, 8'h00, 8'hFF, 1'b1);
    ld_run(32'h00000000, 8'h20, 8'hFF, 1'b1);

    idle(5);
    cyc(1'b1, 32'hABCDEF01, 8'h81, 8'hFF, 1'b0);
    idle(3);
    cyc(1'b1, 32'h00C0FFEE, 8'h04, 8'h7F, 1'b1);
    idle(2 * FRAME);

    ld_run(32'h0000000A, 8'h00, 8'h01, 1'b0);
    ld_run(32'h87654321, 8'h00, 8'hFF, 1'b0);

    idle(SD * 2 + 2);
    rst = 1'b1;
    #1;
    chk("arst_an", 32'(bus.an), 32'hFF);
    chk("arst_seg", 32'(bus.seg), 32'hFF);
    chk("arst_fd", 32'(bus.frame_done), 32'h0);
    #1;
    rst = 1'b0;
    model_reset();
    idle(FRAME + 3);

    repeat (3000) begin
      rb = $urandom >> (4 * $urandom_range(0, 8));
      cyc($urandom_range(0, 15) == 0, rb,
          ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom),
          ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom),
          1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
